// File: rtl/buzzer_tone_gen_if.sv
// buzzer_tone_gen_if: alarm request in, buzzer drive and status out
interface buzzer_tone_gen_if;
    logic buzz_en;
    logic buzzer_out;
    logic active;
    logic timed_out;
    modport master (output buzz_en, input buzzer_out, active, timed_out);
    modport slave (input buzz_en, output buzzer_out, active, timed_out);
endinterface

// File: rtl/buzzer_tone_gen.sv
// buzzer_tone_gen: gates a square-wave tone into a beep cadence with optional auto-stop
module buzzer_tone_gen #(
    parameter int TONE_HALF_PERIOD = 12500,
    parameter int ON_CYCLES        = 25000000,
    parameter int OFF_CYCLES       = 25000000,
    parameter int MAX_BEEPS        = 60
) (
    input logic clk,
    input logic reset_n,
    buzzer_tone_gen_if.slave bus
);
    localparam int TW = TONE_HALF_PERIOD > 1 ? $clog2(TONE_HALF_PERIOD) : 1;
    localparam int CMAX = ON_CYCLES > OFF_CYCLES ? ON_CYCLES : OFF_CYCLES;
    localparam int CW = CMAX > 1 ? $clog2(CMAX) : 1;
    localparam int BW = MAX_BEEPS > 1 ? $clog2(MAX_BEEPS) : 1;
    typedef enum logic [1:0] {IDLE, BEEP_ON, BEEP_OFF, DONE} state_t;
    state_t state, state_nx;
    logic [TW-1:0] tone_cnt, tone_nx;
    logic [CW-1:0] cad_cnt, cad_nx;
    logic [BW-1:0] beep_cnt, beep_nx;
    logic phase, phase_nx;
    // next state and counters; a low buzz_en overrides any terminal count
    always_comb begin
        state_nx = state;
        tone_nx  = tone_cnt;
        cad_nx   = cad_cnt;
        beep_nx  = beep_cnt;
        phase_nx = phase;
        case (state)
            IDLE: begin
                if (bus.buzz_en) begin
                    state_nx = BEEP_ON;
                    tone_nx  = '0;
                    cad_nx   = '0;
                    beep_nx  = '0;
                    phase_nx = 1'b0;
                end
            end
            BEEP_ON: begin
                tone_nx  = (tone_cnt == TW'(TONE_HALF_PERIOD - 1)) ? '0 : tone_cnt + 1'b1;
                phase_nx = phase ^ (tone_cnt == TW'(TONE_HALF_PERIOD - 1));
                cad_nx   = cad_cnt + 1'b1;
                if (cad_cnt == CW'(ON_CYCLES - 1)) begin
                    cad_nx = '0;
                    if (MAX_BEEPS != 0 && 32'(beep_cnt) + 32'd1 == 32'(MAX_BEEPS))
                        state_nx = DONE;
                    else begin
                        state_nx = BEEP_OFF;
                        beep_nx  = (MAX_BEEPS != 0) ? beep_cnt + 1'b1 : beep_cnt;
                    end
                end
            end
            BEEP_OFF: begin
                cad_nx = cad_cnt + 1'b1;
                if (cad_cnt == CW'(OFF_CYCLES - 1)) begin
                    cad_nx   = '0;
                    state_nx = BEEP_ON;
                    tone_nx  = '0;
                    phase_nx = 1'b0;
                end
            end
            DONE: state_nx = DONE;
        endcase
        if (!bus.buzz_en) state_nx = IDLE;
    end
    // state and counter registers; outputs are decoded from next values so they track state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            tone_cnt       <= '0;
            cad_cnt        <= '0;
            beep_cnt       <= '0;
            phase          <= 1'b0;
            bus.buzzer_out <= 1'b0;
            bus.active     <= 1'b0;
            bus.timed_out  <= 1'b0;
        end else begin
            state          <= state_nx;
            tone_cnt       <= tone_nx;
            cad_cnt        <= cad_nx;
            beep_cnt       <= beep_nx;
            phase          <= phase_nx;
            bus.buzzer_out <= (state_nx == BEEP_ON) && phase_nx;
            bus.active     <= (state_nx == BEEP_ON) || (state_nx == BEEP_OFF);
            bus.timed_out  <= (state_nx == DONE);
        end
    end
endmodule
